// File: rtl/shifter_pkg.sv
// Shared types and sign-magnitude field helpers for the shifter family.
// Helpers take a zero-extended operand plus its real width so that one copy serves every N.
package shifter_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} shr_state_t;

  localparam int unsigned SM_MAX_W = 64;

  function automatic logic sign_of(input logic [SM_MAX_W-1:0] v, input int unsigned w);
    return |(v & (SM_MAX_W'(1) << (w - 1)));
  endfunction

  function automatic logic [SM_MAX_W-1:0] mag_of(input logic [SM_MAX_W-1:0] v, input int unsigned w);
    return v & ((SM_MAX_W'(1) << (w - 1)) - SM_MAX_W'(1));
  endfunction

endpackage

// File: rtl/shifter_sr_seq.sv
// Iterative sign-magnitude right shifter: one magnitude bit per clock, sticky lost-bit flag.
// state | meaning
// IDLE  | waiting for i_start
// SHIFT | magnitude shifting right, one bit per edge
// DONE  | result valid for one cycle, i_start may chain the next operation
module shifter_sr_seq
  import shifter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_out,
  output logic         o_err,
  output logic         o_inexact
);

  shr_state_t state, state_nxt;

  logic [N-2:0] mag, mag_nxt;
  logic [N-2:0] cnt, cnt_nxt;
  logic         sign, sign_nxt;
  logic         sticky, sticky_nxt;

  logic         res_load;
  logic [N-1:0] res_out;
  logic         res_err;
  logic         res_inexact;

  logic         a_sign, b_sign;
  logic [N-2:0] a_mag, b_mag;

  assign a_sign = sign_of(SM_MAX_W'(i_a), N);
  assign b_sign = sign_of(SM_MAX_W'(i_b), N);
  assign a_mag  = (N-1)'(mag_of(SM_MAX_W'(i_a), N));
  assign b_mag  = (N-1)'(mag_of(SM_MAX_W'(i_b), N));

  always_comb begin
    state_nxt   = state;
    mag_nxt     = mag;
    cnt_nxt     = cnt;
    sign_nxt    = sign;
    sticky_nxt  = sticky;
    res_load    = 1'b0;
    res_out     = '0;
    res_err     = 1'b0;
    res_inexact = 1'b0;

    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (i_start) begin
          sign_nxt   = a_sign;
          mag_nxt    = a_mag;
          cnt_nxt    = b_mag;
          sticky_nxt = 1'b0;
          if (b_sign) begin
            // Negative amount: zero result, error only, nothing shifted.
            state_nxt = DONE;
            res_load  = 1'b1;
            res_err   = 1'b1;
          end else if (b_mag == '0 || a_mag == '0) begin
            state_nxt = DONE;
            res_load  = 1'b1;
            res_out   = {a_sign, a_mag};
          end else begin
            state_nxt = SHIFT;
          end
        end
      end

      SHIFT: begin
        sticky_nxt = sticky | mag[0];
        mag_nxt    = mag >> 1;
        cnt_nxt    = (cnt != '0) ? cnt - 1'b1 : cnt;
        // Stop early once the magnitude is exhausted; further shifts change nothing.
        if (cnt_nxt == '0 || mag_nxt == '0) begin
          state_nxt   = DONE;
          res_load    = 1'b1;
          res_out     = {sign, mag_nxt};
          res_inexact = sticky_nxt;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      mag       <= '0;
      cnt       <= '0;
      sign      <= 1'b0;
      sticky    <= 1'b0;
      o_out     <= '0;
      o_err     <= 1'b0;
      o_inexact <= 1'b0;
    end else begin
      state  <= state_nxt;
      mag    <= mag_nxt;
      cnt    <= cnt_nxt;
      sign   <= sign_nxt;
      sticky <= sticky_nxt;
      if (res_load) begin
        o_out     <= res_out;
        o_err     <= res_err;
        o_inexact <= res_inexact;
      end
    end
  end

  assign o_busy = (state == SHIFT);
  assign o_done = (state == DONE);

endmodule
